averager_scheduler: RTL and testbench
=====================================

# averager_scheduler

Sequencing controller for the 16-lane averager tree in the digital compute datapath. It accepts window commands, pulses the tree's start, and gates source beats into the tree. It pads the tree pipeline with zero beats, discards stale tree outputs, accumulates the averaged samples of each window, and streams one signed sum per window downstream with backpressure.

## Interface
Parameters:
- IN_DATA_WIDTH, 256, source/tree input beat width (16 lanes x 16 bit)
- OUT_DATA_WIDTH, 16, tree output width (signed)
- ACC_WIDTH, 32, window sum width
- IDX_WIDTH, 8, window count/index width
- TREE_LATENCY, 4, beats until a tree output reflects the first beat of a window
- STALL_TIMEOUT, 1024, cycles without a source beat in FEED before abort; 0 disables

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_persist_len  in  16  beats per window
- cmd_num_windows  in  IDX_WIDTH  windows in command
- src_tdata  in  IN_DATA_WIDTH  source beat
- src_tvalid / src_tready  in/out  1  source handshake
- avg_start  out  1  one-cycle start pulse to the tree
- avg_persist_len  out  16  latched window length to the tree
- avg_s_tdata  out  IN_DATA_WIDTH  tree input
- avg_s_tvalid  out  1  tree input valid
- avg_m_tdata  in  OUT_DATA_WIDTH  tree output
- avg_m_tvalid  in  1  tree output valid
- res_tdata  out  ACC_WIDTH  window sum
- res_tindex  out  IDX_WIDTH  window index, 0-based
- res_tlast  out  1  last window of the command
- res_tvalid / res_tready  out/in  1  result handshake
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when a command completes
- err_timeout  out  1  one-cycle pulse when a command aborts

## Operation
- States: IDLE, START, FEED, FLUSH, WAIT, EMIT.
- IDLE: cmd_ready=1. On accept, latch L=max(cmd_persist_len,1) and N=cmd_num_windows, set window index=0.
  - N=0: pulse done next cycle, stay in IDLE.
  - Otherwise: go to START.
- START (1 cycle): avg_start=1, avg_s_tvalid=0. Clear acc, beat count b and sample count s. Go to FEED.
- FEED:
  - src_tready=1; avg_s_tvalid=src_tvalid; avg_s_tdata=src_tdata.
  - Each beat: b++, stall counter cleared.
  - After L beats: go to FLUSH.
  - STALL_TIMEOUT consecutive cycles without a beat: err_timeout pulse, go to IDLE, no result emitted.
- FLUSH: src_tready=0, avg_s_tvalid=1, avg_s_tdata=0. Issue TREE_LATENCY-1 pad beats, then go to WAIT.
- WAIT (1 cycle): absorbs the final tree output, then go to EMIT.
- Sampling, in any state:
  - Condition: avg_m_tvalid=1, s<L, and the beats issued before the previous cycle number at least TREE_LATENCY-1.
  - Action: acc += sign-extended avg_m_tdata; s++.
  - Earlier tree outputs are stale and are ignored.
- EMIT: res_tvalid=1, res_tdata=acc, res_tindex=index, res_tlast=(index==N-1). Outputs hold until res_tready.
  - Handshake on a non-last window: index++, go to START.
  - Handshake on the last window: done pulse next cycle, go to IDLE.
- Arithmetic: acc is two's complement and wraps modulo 2^ACC_WIDTH.
- avg_persist_len holds the latched L from accept until IDLE is re-entered; it is 0 in IDLE.
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- Reset, including mid-operation: state IDLE; all outputs 0 except cmd_ready=1; acc, counters and index cleared; the in-flight window is dropped with no res_tvalid and no done.

## Timing
- Command accepted in cycle 0; avg_start in cycle 1; first possible beat in cycle 2.
- Continuous source: beats in cycles 2..L+1, pad beats in L+2..L+4, last sample in cycle L+5, res_tvalid from cycle L+6.
- Next window's avg_start is the cycle after the res handshake.
- res_tready low stalls the scheduler in EMIT; src_tready stays 0 throughout.
- Source gaps extend FEED one cycle per gap; the sum is unchanged.
- avg_s_tvalid is never high in START, WAIT, EMIT or IDLE.
- src_tready is combinational from state only.

## Test plan
- L=4, N=1, lanes alternating 10/30, source always valid -> avg_start in cycle 1; res_tvalid in cycle 10; res_tdata=80, index 0, tlast=1; done in the cycle after the handshake.
- L=3, N=3, res_tready held low 5 cycles on window 1 -> results indexed 0,1,2 with tlast only on 2; src_tready=0 and avg_s_tvalid=0 during the stall; each sum correct.
- Back-to-back windows, L=2, lanes 100 then 50 -> sums 200 then 100; stale tree outputs after the second avg_start do not contaminate the second sum.
- src_tvalid toggling every other cycle, L=4, lanes 20 -> sum 80; avg_s_tvalid mirrors src_tvalid only in FEED; exactly 3 zero pad beats.
- STALL_TIMEOUT=16, source stops after 2 of L=8 beats -> err_timeout pulse 16 cycles after the last beat; IDLE; no res_tvalid; no done.
- rst asserted mid-FEED, then N=0 command -> all outputs at reset values next cycle; N=0 gives a done pulse in cycle 1 with no avg_start; cmd_persist_len=0 behaves as L=1.

Source files
------------

// File: rtl/averager_scheduler.sv
// averager_scheduler
//   Sequences the 16-lane averager tree. It accepts a window command and
//   pulses the tree start for each window. It gates source beats into the
//   tree, then pads the tree pipeline with zero beats. It drops tree outputs
//   that predate the current window and sums the averaged samples. Each
//   window sum goes out on a result stream that honours backpressure.
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   cmd_*                       window command (persist length, window count)
//   src_*                       source beat stream into the scheduler
//   avg_start/avg_persist_len   tree start pulse and latched window length
//   avg_s_*                     beats into the tree
//   avg_m_*                     averaged samples out of the tree
//   res_*                       one signed sum per window, index, last flag
//   busy, done, err_timeout     status: active, command complete, aborted
module averager_scheduler #(
  parameter int IN_DATA_WIDTH  = 256,
  parameter int OUT_DATA_WIDTH = 16,
  parameter int ACC_WIDTH      = 32,
  parameter int IDX_WIDTH      = 8,
  parameter int TREE_LATENCY   = 4,
  parameter int STALL_TIMEOUT  = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [15:0]               cmd_persist_len,
  input  logic [IDX_WIDTH-1:0]      cmd_num_windows,
  input  logic [IN_DATA_WIDTH-1:0]  src_tdata,
  input  logic                      src_tvalid,
  output logic                      src_tready,
  output logic                      avg_start,
  output logic [15:0]               avg_persist_len,
  output logic [IN_DATA_WIDTH-1:0]  avg_s_tdata,
  output logic                      avg_s_tvalid,
  input  logic [OUT_DATA_WIDTH-1:0] avg_m_tdata,
  input  logic                      avg_m_tvalid,
  output logic [ACC_WIDTH-1:0]      res_tdata,
  output logic [IDX_WIDTH-1:0]      res_tindex,
  output logic                      res_tlast,
  output logic                      res_tvalid,
  input  logic                      res_tready,
  output logic                      busy,
  output logic                      done,
  output logic                      err_timeout
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_FEED, S_FLUSH, S_WAIT, S_EMIT} state_t;

  localparam int PADS = TREE_LATENCY - 1;
  localparam int IW   = $clog2(TREE_LATENCY + 1);
  localparam int SW   = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;

  state_t               state_q, state_d;
  logic [15:0]          len_q, len_d;
  logic [IDX_WIDTH-1:0] num_q, num_d, idx_q, idx_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [15:0]          beat_q, beat_d, smp_q, smp_d;
  logic [IW-1:0]        pad_q, pad_d;
  logic [IW-1:0]        iss_q, iss_d;    // beats issued this window (saturating)
  logic [IW-1:0]        issp_q, issp_d;  // iss_q as it was one cycle earlier
  logic [SW-1:0]        stall_q, stall_d;
  logic                 done_q, done_d;
  logic                 emit, sample, stall_hit;

  assign cmd_ready       = (state_q == S_IDLE);
  assign busy            = (state_q != S_IDLE);
  assign src_tready      = (state_q == S_FEED);
  assign avg_s_tvalid    = ((state_q == S_FEED) && src_tvalid) || (state_q == S_FLUSH);
  assign avg_s_tdata     = (state_q == S_FEED) ? src_tdata : '0;
  assign avg_persist_len = busy ? len_q : 16'd0;
  assign emit            = (state_q == S_EMIT);
  assign res_tdata       = emit ? acc_q : '0;
  assign res_tindex      = emit ? idx_q : '0;
  assign res_tlast       = emit && (idx_q == num_q - IDX_WIDTH'(1));
  assign done            = done_q;

  // A tree output is current only once TREE_LATENCY-1 beats had entered the
  // tree before the previous cycle; anything earlier belongs to old data.
  assign sample    = avg_m_tvalid && (smp_q < len_q) && (issp_q == IW'(PADS));
  assign stall_hit = (STALL_TIMEOUT != 0) && (stall_q == SW'(STALL_TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    num_d       = num_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    beat_d      = beat_q;
    smp_d       = smp_q;
    pad_d       = pad_q;
    stall_d     = stall_q;
    done_d      = 1'b0;
    avg_start   = 1'b0;
    res_tvalid  = 1'b0;
    err_timeout = 1'b0;
    iss_d       = (avg_s_tvalid && (iss_q != IW'(PADS))) ? iss_q + IW'(1) : iss_q;
    issp_d      = iss_q;

    if (sample) begin
      acc_d = acc_q + ACC_WIDTH'($signed(avg_m_tdata));
      smp_d = smp_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          len_d = (cmd_persist_len == 16'd0) ? 16'd1 : cmd_persist_len;
          num_d = cmd_num_windows;
          idx_d = '0;
          if (cmd_num_windows == '0) done_d = 1'b1;
          else                       state_d = S_START;
        end
      end
      S_START: begin
        avg_start = 1'b1;
        acc_d     = '0;
        beat_d    = '0;
        smp_d     = '0;
        pad_d     = '0;
        stall_d   = '0;
        iss_d     = '0;
        issp_d    = '0;
        state_d   = S_FEED;
      end
      S_FEED: begin
        if (src_tvalid) begin
          beat_d  = beat_q + 16'd1;
          stall_d = '0;
          if (beat_q == len_q - 16'd1) state_d = (PADS > 0) ? S_FLUSH : S_WAIT;
        end else if (stall_hit) begin
          err_timeout = 1'b1;
          state_d     = S_IDLE;
        end else begin
          stall_d = stall_q + SW'(1);
        end
      end
      S_FLUSH: begin
        pad_d = pad_q + IW'(1);
        if (pad_q == IW'(PADS - 1)) state_d = S_WAIT;
      end
      S_WAIT: state_d = S_EMIT;
      S_EMIT: begin
        res_tvalid = 1'b1;
        if (res_tready) begin
          if (res_tlast) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + IDX_WIDTH'(1);
            state_d = S_START;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      beat_q  <= '0;
      smp_q   <= '0;
      pad_q   <= '0;
      iss_q   <= '0;
      issp_q  <= '0;
      stall_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      beat_q  <= beat_d;
      smp_q   <= smp_d;
      pad_q   <= pad_d;
      iss_q   <= iss_d;
      issp_q  <= issp_d;
      stall_q <= stall_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_averager_scheduler.sv
module tb_averager_scheduler;
  localparam int DW = 256;
  localparam int OW = 16;
  localparam int AW = 32;
  localparam int XW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [15:0]   cmd_persist_len;
  logic [XW-1:0] cmd_num_windows;
  logic [DW-1:0] src_tdata;
  logic          src_tvalid, src_tready;
  logic          avg_start;
  logic [15:0]   avg_persist_len;
  logic [DW-1:0] avg_s_tdata;
  logic          avg_s_tvalid;
  logic [OW-1:0] avg_m_tdata;
  logic          avg_m_tvalid;
  logic [AW-1:0] res_tdata;
  logic [XW-1:0] res_tindex;
  logic          res_tlast, res_tvalid, res_tready;
  logic          busy, done, err_timeout;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  averager_scheduler #(
    .IN_DATA_WIDTH(DW), .OUT_DATA_WIDTH(OW), .ACC_WIDTH(AW), .IDX_WIDTH(XW),
    .TREE_LATENCY(4), .STALL_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_persist_len(cmd_persist_len), .cmd_num_windows(cmd_num_windows),
    .src_tdata(src_tdata), .src_tvalid(src_tvalid), .src_tready(src_tready),
    .avg_start(avg_start), .avg_persist_len(avg_persist_len),
    .avg_s_tdata(avg_s_tdata), .avg_s_tvalid(avg_s_tvalid),
    .avg_m_tdata(avg_m_tdata), .avg_m_tvalid(avg_m_tvalid),
    .res_tdata(res_tdata), .res_tindex(res_tindex), .res_tlast(res_tlast),
    .res_tvalid(res_tvalid), .res_tready(res_tready),
    .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  // Tree model: a beat-advanced 3-deep pipeline plus output register, so the
  // 4th beat after start presents the average of the 1st. A start loads a
  // junk value so that early outputs are visibly stale.
  logic signed [15:0] sr [3];

  function automatic logic signed [15:0] lane_avg(input logic [DW-1:0] d);
    logic signed [19:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s = s + 20'($signed(d[i*16 +: 16]));
    return 16'(s >>> 4);
  endfunction

  function automatic logic [DW-1:0] lanes(input logic [15:0] a, input logic [15:0] b);
    logic [DW-1:0] d;
    for (int i = 0; i < 16; i++) d[i*16 +: 16] = (i % 2 == 0) ? a : b;
    return d;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sr[0] <= '0; sr[1] <= '0; sr[2] <= '0;
      avg_m_tdata  <= '0;
      avg_m_tvalid <= 1'b0;
    end else if (avg_start) begin
      sr[0] <= 16'sd1000; sr[1] <= 16'sd1000; sr[2] <= 16'sd1000;
      avg_m_tvalid <= 1'b0;
    end else if (avg_s_tvalid) begin
      sr[0] <= lane_avg(avg_s_tdata);
      sr[1] <= sr[0];
      sr[2] <= sr[1];
      avg_m_tdata  <= sr[2];
      avg_m_tvalid <= 1'b1;
    end else begin
      avg_m_tvalid <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a command in the current cycle (cycle 0); returns settled in cycle 1.
  task automatic send_cmd(input logic [15:0] l, input logic [XW-1:0] n);
    cmd_valid = 1'b1; cmd_persist_len = l; cmd_num_windows = n;
    #1;
    chk("cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    #1;
  endtask

  // Step until res_tvalid; tallies pad beats and feed/pad violations on the way.
  task automatic wait_res(input int budget, input bit toggle,
                          output int ncyc, output int pads, output int bad);
    ncyc = 0; pads = 0; bad = 0;
    while (!res_tvalid && ncyc < budget) begin
      if (src_tready) begin
        if (avg_s_tvalid !== src_tvalid) bad++;
      end else if (avg_s_tvalid) begin
        pads++;
        if (avg_s_tdata != '0) bad++;
      end
      step();
      if (toggle) src_tvalid = ~src_tvalid;
      #1;
      ncyc++;
    end
    chk("res_tvalid_wait", res_tvalid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int nc, pd, bd, ecyc, npulse, nres, ndone;
    rst = 1'b1; cmd_valid = 1'b0; cmd_persist_len = '0; cmd_num_windows = '0;
    src_tdata = '0; src_tvalid = 1'b0; res_tready = 1'b1;
    repeat (3) step();
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_res_tvalid", res_tvalid, 0);
    chk("rst_plen", avg_persist_len, 0);
    rst = 1'b0;
    step();

    // T1: L=4, N=1, lanes 10/30 -> avg 20, sum 80, result in cycle 10
    src_tdata = lanes(16'd10, 16'd30); src_tvalid = 1'b1;
    send_cmd(16'd4, 8'd1);
    chk("t1_start", avg_start, 1);
    chk("t1_svalid_start", avg_s_tvalid, 0);
    chk("t1_plen", avg_persist_len, 4);
    wait_res(40, 1'b0, nc, pd, bd);
    chk("t1_res_cycle", 1 + nc, 10);
    chk("t1_sum", res_tdata, 80);
    chk("t1_index", res_tindex, 0);
    chk("t1_tlast", res_tlast, 1);
    chk("t1_pads", pd, 3);
    chk("t1_feed", bd, 0);
    step();
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    chk("t1_plen_idle", avg_persist_len, 0);
    step();
    chk("t1_done_pulse", done, 0);

    // T2: L=3, N=3, window w lanes 10*(w+1); window 1 held 5 cycles
    src_tdata = lanes(16'd10, 16'd10);
    send_cmd(16'd3, 8'd3);
    for (int w = 0; w < 3; w++) begin
      if (w > 0) begin
        chk("t2_restart", avg_start, 1);
        src_tdata = lanes(16'(10 * (w + 1)), 16'(10 * (w + 1)));
      end
      res_tready = (w != 1);
      wait_res(40, 1'b0, nc, pd, bd);
      chk("t2_sum", res_tdata, 64'(30 * (w + 1)));
      chk("t2_index", res_tindex, 64'(w));
      chk("t2_tlast", res_tlast, 64'(w == 2));
      chk("t2_feed", bd, 0);
      if (w == 1) begin
        for (int k = 0; k < 5; k++) begin
          chk("t2_hold_valid", res_tvalid, 1);
          chk("t2_hold_sum", res_tdata, 60);
          chk("t2_hold_srdy", src_tready, 0);
          chk("t2_hold_svld", avg_s_tvalid, 0);
          if (k < 4) step();
        end
        res_tready = 1'b1;
        #1;
      end
      step();
    end
    chk("t2_done", done, 1);

    // T3: back-to-back L=2 windows, lanes 100 then 50 -> 200, 100
    step();
    src_tdata = lanes(16'd100, 16'd100);
    send_cmd(16'd2, 8'd2);
    wait_res(40, 1'b0, nc, pd, bd);
    chk("t3_res_cycle", 1 + nc, 8);
    chk("t3_sum0", res_tdata, 200);
    chk("t3_tlast0", res_tlast, 0);
    src_tdata = lanes(16'd50, 16'd50);
    step();
    chk("t3_restart", avg_start, 1);
    wait_res(40, 1'b0, nc, pd, bd);
    chk("t3_sum1", res_tdata, 100);
    chk("t3_index1", res_tindex, 1);
    chk("t3_tlast1", res_tlast, 1);
    step();
    chk("t3_done", done, 1);

    // T4: src_tvalid toggling, L=4, lanes 20 -> sum 80, 3 pads, EMIT in cycle 13
    step();
    src_tdata = lanes(16'd20, 16'd20);
    send_cmd(16'd4, 8'd1);
    src_tvalid = 1'b0;
    #1;
    wait_res(60, 1'b1, nc, pd, bd);
    chk("t4_res_cycle", 1 + nc, 13);
    chk("t4_sum", res_tdata, 80);
    chk("t4_pads", pd, 3);
    chk("t4_mirror", bd, 0);
    src_tvalid = 1'b0;
    step();
    chk("t4_done", done, 1);

    // T5: timeout -- beats in cycles 2,3 of L=8, err_timeout in cycle 19
    step();
    send_cmd(16'd8, 8'd1);
    src_tvalid = 1'b1;
    step();
    step();
    step();
    src_tvalid = 1'b0;
    #1;
    ecyc = -1; npulse = 0; nres = 0; ndone = 0;
    for (int c = 4; c <= 40; c++) begin
      if (err_timeout) begin npulse++; ecyc = c; end
      if (res_tvalid) nres++;
      if (done) ndone++;
      step();
    end
    chk("t5_err_cycle", ecyc, 19);
    chk("t5_err_pulses", npulse, 1);
    chk("t5_no_res", nres, 0);
    chk("t5_no_done", ndone, 0);
    chk("t5_idle", busy, 0);

    // T6: reset mid-FEED, then N=0, then persist_len 0 as L=1
    src_tdata = lanes(16'd40, 16'd40); src_tvalid = 1'b1;
    send_cmd(16'd8, 8'd1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("t6_cmd_ready", cmd_ready, 1);
    chk("t6_busy", busy, 0);
    chk("t6_start", avg_start, 0);
    chk("t6_plen", avg_persist_len, 0);
    chk("t6_srdy", src_tready, 0);
    chk("t6_svld", avg_s_tvalid, 0);
    chk("t6_res_tvalid", res_tvalid, 0);
    chk("t6_done", done, 0);
    chk("t6_err", err_timeout, 0);
    send_cmd(16'd0, 8'd0);
    chk("t6_n0_done", done, 1);
    chk("t6_n0_start", avg_start, 0);
    chk("t6_n0_busy", busy, 0);
    step();
    chk("t6_n0_pulse", done, 0);
    send_cmd(16'd0, 8'd1);
    chk("t6_l1_plen", avg_persist_len, 1);
    wait_res(40, 1'b0, nc, pd, bd);
    chk("t6_l1_res_cycle", 1 + nc, 7);
    chk("t6_l1_sum", res_tdata, 40);
    chk("t6_l1_tlast", res_tlast, 1);
    step();
    chk("t6_l1_done", done, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
